imem_loader: RTL
================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 8, word-address width of instruction memory (depth 2^ADDR_W words).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  single-cycle request to begin a load session; honoured only in IDLE or ERR.
REQ-005 in_data  input  8  byte stream from host.
REQ-006 in_valid  input  1  in_data valid this cycle.
REQ-007 in_ready  output  1  loader accepts a byte this cycle; byte transfers when in_valid & in_ready.
REQ-008 imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 imem_addr  output  ADDR_W  word address for the write.
REQ-010 imem_wdata  output  32  instruction word for the write.
REQ-011 cpu_hold  output  1  holds the pipeline in reset while the loader owns instruction memory.
REQ-012 done  output  1  one-cycle pulse on successful session completion.
REQ-013 error  output  1  sticky flag: length header exceeded memory depth.

Function
REQ-014 FSM states SHALL be IDLE, LEN_HI, LEN_LO, DATA, DONE, ERR.
REQ-015 IDLE: in_ready=0, cpu_hold=0; start -> LEN_HI, clear word address, byte counter and error.
REQ-016 LEN_HI: accepted byte -> N[15:8]; next LEN_LO.
REQ-017 LEN_LO: accepted byte -> N[7:0]; N==0 -> DONE; N>2^ADDR_W -> ERR; else -> DATA.
REQ-018 DATA: bytes assembled big-endian, first byte of a word -> bits [31:24], fourth -> [7:0].
REQ-019 On acceptance of the fourth byte of a word, imem_we SHALL be 1 in the following cycle with imem_wdata=assembled word and imem_addr=current word address; otherwise imem_we=0.
REQ-020 Word address SHALL increment by 1 after each write; the word count check guarantees no wrap.
REQ-021 After the Nth word write is issued, FSM -> DONE; no further bytes accepted (in_ready=0 from the cycle after the last byte).
REQ-022 DONE lasts exactly one cycle, done=1, then IDLE.
REQ-023 in_ready SHALL be 1 in LEN_HI, LEN_LO and DATA, 0 in IDLE, DONE and ERR; in_valid without in_ready is ignored, no byte lost or duplicated under arbitrary in_valid gaps.
REQ-024 cpu_hold SHALL be 1 in LEN_HI, LEN_LO, DATA, DONE and ERR, and 0 from the first IDLE cycle after DONE.
REQ-025 ERR: error=1, cpu_hold=1, no writes; start -> LEN_HI with error cleared; otherwise remain in ERR.
REQ-026 start in LEN_HI, LEN_LO, DATA or DONE SHALL be ignored.
REQ-027 start and in_valid asserted together in IDLE: only start is acted on; that byte is not accepted.
REQ-028 done and error SHALL never be 1 in the same cycle.
REQ-029 Maximum throughput: one byte per cycle, i.e. one word write every 4 cycles.

Reset
REQ-030 reset SHALL force IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=0, done=0, error=0, byte counter=0, word count=0.
REQ-031 reset mid-session SHALL discard any partial word and issue no write in the cycle following reset; reset has priority over all other inputs.

Verification
REQ-032 start, stream 00 02 12 34 56 78 9A BC DE F0 back-to-back -> writes addr0=0x12345678, addr1=0x9ABCDEF0, each one cycle after the fourth byte; done pulse once; cpu_hold falls the cycle after done.
REQ-033 start, header 00 00 -> no writes, DONE one cycle after the second header byte, cpu_hold back to 0.
REQ-034 ADDR_W=8, header 01 01 (N=257) -> ERR, error=1, cpu_hold=1, in_ready=0, no writes; next start clears error; header 01 00 with 1024 data bytes writes addr0..255, ends with done.
REQ-035 Random in_valid gaps (about 50% duty) with same stream as REQ-032 -> identical words and addresses, no extra or missing writes.
REQ-036 reset after 6 data bytes of a 2-word session -> all outputs at reset values next cycle, no write of the partial word; new session writes from addr 0.
REQ-037 start pulsed during DATA -> ignored, session completes normally with correct word count.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: receives a big-endian length-prefixed byte stream from a host
// and writes it as 32-bit words into instruction memory. While a session is
// open, the CPU pipeline is held in reset.
//
// state  | meaning
// IDLE   | no session open, CPU runs, waiting for start
// LEN_HI | taking the upper byte of the word count N
// LEN_LO | taking the lower byte of N, then range-checking it
// DATA   | assembling bytes into words and writing them out
// DONE   | one-cycle completion pulse
// ERR    | N exceeded memory depth; waits for a new start
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [7:0]        i_in_data,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic              o_cpu_hold,
  output logic              o_done,
  output logic              o_error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_DONE, S_ERR
  } state_t;

  // Memory depth in words; N above this cannot fit without wrapping.
  localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

  state_t              r_state;
  state_t              w_next;
  logic [7:0]          r_len_hi;
  logic [15:0]         r_words_left;
  logic [1:0]          r_byte_cnt;
  logic [23:0]         r_shift;
  logic                r_we;
  logic [31:0]         r_wdata;
  logic [ADDR_W-1:0]   r_addr;
  logic                w_busy;
  logic                w_accept;
  logic                w_word_done;
  logic                w_start_ok;
  logic [16:0]         w_len;

  // Acceptance is decoded from the state register only, so the byte handshake
  // never depends combinationally on the next-state logic.
  assign w_busy      = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) || (r_state == S_DATA);
  assign w_accept    = i_in_valid && w_busy;
  assign w_word_done = w_accept && (r_state == S_DATA) && (r_byte_cnt == 2'd3);
  assign w_start_ok  = i_start && ((r_state == S_IDLE) || (r_state == S_ERR));
  assign w_len       = {1'b0, r_len_hi, i_in_data};

  assign o_imem_we    = r_we;
  assign o_imem_wdata = r_wdata;
  assign o_imem_addr  = r_addr;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    w_next     = r_state;
    o_in_ready = 1'b0;
    o_cpu_hold = 1'b1;
    o_done     = 1'b0;
    o_error    = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_cpu_hold = 1'b0;
        if (i_start) w_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        o_in_ready = 1'b1;
        if (i_in_valid) w_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        o_in_ready = 1'b1;
        if (i_in_valid) begin
          if (w_len == 17'd0)    w_next = S_DONE;
          else if (w_len > DEPTH) w_next = S_ERR;
          else                    w_next = S_DATA;
        end
      end
      S_DATA: begin
        o_in_ready = 1'b1;
        if (w_word_done && (r_words_left == 16'd1)) w_next = S_DONE;
      end
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      S_ERR: begin
        o_error = 1'b1;
        if (i_start) w_next = S_LEN_HI;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: length capture, word assembly, write strobe and address.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_len_hi     <= 8'd0;
      r_words_left <= 16'd0;
      r_byte_cnt   <= 2'd0;
      r_shift      <= 24'd0;
      r_we         <= 1'b0;
      r_wdata      <= 32'd0;
      r_addr       <= '0;
    end else begin
      r_we <= w_word_done;
      // Address advances once the write it labels has been presented.
      if (r_we) r_addr <= r_addr + 1'b1;
      if (w_start_ok) begin
        r_addr     <= '0;
        r_byte_cnt <= 2'd0;
        r_shift    <= 24'd0;
      end else if (w_accept) begin
        case (r_state)
          S_LEN_HI: r_len_hi <= i_in_data;
          S_LEN_LO: r_words_left <= {r_len_hi, i_in_data};
          S_DATA: begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            r_shift    <= {r_shift[15:0], i_in_data};
            if (r_byte_cnt == 2'd3) begin
              r_wdata      <= {r_shift, i_in_data};
              r_words_left <= r_words_left - 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
